// File: rtl/code_lock.sv
// Keypad combination lock: checks CODE_LEN key pulses against CODE, holds the lock open, and
// optionally locks the keypad out after MAX_FAILS rejected attempts (`define CODE_LOCK_LOCKOUT_EN).
module code_lock #(
  parameter int                      CODE_LEN       = 4,
  parameter logic [2*CODE_LEN-1:0]   CODE           = 8'hE4,
  parameter int                      OPEN_CYCLES    = 3_000_000,
  parameter int                      TIMEOUT_CYCLES = 5_000_000,
  parameter int                      MAX_FAILS      = 3,
  parameter int                      LOCKOUT_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keys,
  output logic       unlocked,
  output logic       fail,
  output logic       locked_out,
  output logic [3:0] digit_cnt
);

  localparam int MAX_OT = (OPEN_CYCLES > TIMEOUT_CYCLES) ? OPEN_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_P  = (MAX_OT > LOCKOUT_CYCLES) ? MAX_OT : LOCKOUT_CYCLES;
  localparam int TW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  if (CODE_LEN < 1 || CODE_LEN > 8 || MAX_FAILS < 1 || MAX_FAILS > 15) begin : g_param_check
    $error("code_lock: CODE_LEN must be 1..8 and MAX_FAILS 1..15");
  end

  typedef enum logic [1:0] {IDLE, ENTRY, OPEN, LOCKOUT} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          mismatch;

  logic          press;
  logic          last;
  logic          mismatch_n;
  logic [3:0]    cnt_n;

  // One-hot key pattern expected for combination entry idx.
  function automatic logic [3:0] expected_key(input logic [3:0] idx);
    logic [2*CODE_LEN-1:0] shifted;
    shifted = CODE >> {idx, 1'b0};
    return 4'b0001 << shifted[1:0];
  endfunction

  always_comb begin
    press      = |keys;
    cnt_n      = digit_cnt + 4'd1;
    last       = (cnt_n == 4'(CODE_LEN));
    mismatch_n = ((state == ENTRY) ? mismatch : 1'b0) | (keys != expected_key(digit_cnt));
  end

`ifdef CODE_LOCK_LOCKOUT_EN
  logic [3:0] fail_cnt;
  logic [3:0] fail_cnt_n;

  always_comb fail_cnt_n = (fail_cnt == 4'd15) ? 4'd15 : fail_cnt + 4'd1;
`else
  assign locked_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      mismatch  <= 1'b0;
      digit_cnt <= 4'd0;
      unlocked  <= 1'b0;
      fail      <= 1'b0;
`ifdef CODE_LOCK_LOCKOUT_EN
      locked_out <= 1'b0;
      fail_cnt   <= 4'd0;
`endif
    end else begin
      fail <= 1'b0;
      case (state)
        IDLE, ENTRY: begin
          if (press) begin
            if (last) begin
              digit_cnt <= 4'd0;
              mismatch  <= 1'b0;
              if (!mismatch_n) begin
                state    <= OPEN;
                unlocked <= 1'b1;
                timer    <= TW'(OPEN_CYCLES - 1);
`ifdef CODE_LOCK_LOCKOUT_EN
                fail_cnt <= 4'd0;
`endif
              end else begin
                fail  <= 1'b1;
                state <= IDLE;
`ifdef CODE_LOCK_LOCKOUT_EN
                fail_cnt <= fail_cnt_n;
                if (fail_cnt_n >= 4'(MAX_FAILS)) begin
                  state      <= LOCKOUT;
                  locked_out <= 1'b1;
                  timer      <= TW'(LOCKOUT_CYCLES - 1);
                end
`endif
              end
            end else begin
              // A press always wins over a simultaneous inactivity expiry.
              state     <= ENTRY;
              digit_cnt <= cnt_n;
              mismatch  <= mismatch_n;
              timer     <= TW'(TIMEOUT_CYCLES - 1);
            end
          end else if (state == ENTRY) begin
            if (timer == '0) begin
              state     <= IDLE;
              digit_cnt <= 4'd0;
              mismatch  <= 1'b0;
            end else begin
              timer <= timer - 1'b1;
            end
          end
        end
        OPEN: begin
          if (timer == '0) begin
            state    <= IDLE;
            unlocked <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
`ifdef CODE_LOCK_LOCKOUT_EN
        LOCKOUT: begin
          if (timer == '0) begin
            state      <= IDLE;
            locked_out <= 1'b0;
            fail_cnt   <= 4'd0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/code_lock.md
# code_lock

Sequencing controller for the debounced keypad front end: it consumes the one-cycle key pulses and checks them against a fixed combination. It drives an unlock output for a fixed hold time. It counts failed attempts and can lock the keypad out after repeated failures. It sits directly behind the keypad pulse generator in the 1 MHz clock domain and drives the lock actuator and status LEDs.

## Interface

- CODE_LEN, 4: presses per combination, legal range 1..8
- CODE, 8'hE4: combination as 2-bit key indices, width 2*CODE_LEN; entry i in bits [2i+1:2i]; the default is keys 0,1,2,3
- OPEN_CYCLES, 3_000_000: unlock hold time in clk cycles (3 s)
- TIMEOUT_CYCLES, 5_000_000: inactivity limit during entry, in clk cycles
- MAX_FAILS, 3: failed attempts that trigger lockout, range 1..15
- LOCKOUT_CYCLES, 10_000_000: lockout duration in clk cycles

- clk  in  1  system clock, 1 MHz
- rst  in  1  synchronous, active-high reset
- keys  in  4  one-cycle key pulses, one bit per key
- unlocked  out  1  high while the lock is open
- fail  out  1  one-cycle pulse on a rejected combination
- locked_out  out  1  high during lockout
- digit_cnt  out  4  presses accepted in the current attempt

## Operation

- States: IDLE, ENTRY, OPEN, LOCKOUT. All outputs are registered.
- Press: any cycle where keys != 0. A one-hot press uses the index of its set bit. A multi-bit press counts as one press that is always a mismatch.
- IDLE: digit_cnt=0.
  - A press stores its match result for entry 0 in a sticky mismatch flag and sets digit_cnt=1.
  - If CODE_LEN>1, go to ENTRY. If CODE_LEN=1, evaluate immediately.
- ENTRY: each press compares against entry digit_cnt, ORs the result into the mismatch flag and increments digit_cnt.
  - No early abort on a mismatch: all CODE_LEN presses are always taken.
- Evaluation happens on the press that makes digit_cnt reach CODE_LEN.
  - Match: go to OPEN, clear the fail counter.
  - Mismatch: pulse fail, increment the fail counter (saturating at 15), go to IDLE, or to LOCKOUT when the macro is enabled and the counter reaches MAX_FAILS.
  - digit_cnt returns to 0 in both cases.
- ENTRY inactivity: the timer reloads on every press. Exactly TIMEOUT_CYCLES cycles without a press -> IDLE.
  - digit_cnt and the mismatch flag clear. No fail pulse. The fail counter is unchanged.
- OPEN: unlocked=1 for exactly OPEN_CYCLES cycles, then IDLE. Keys are ignored; no relock on a press.
- LOCKOUT: locked_out=1 for exactly LOCKOUT_CYCLES cycles, then IDLE with the fail counter cleared. Keys are ignored.
- A single shared down-counter serves the timeout, open and lockout timers. Its width is clog2 of the largest of the three parameters.

## Timing

- Reset values: state IDLE, unlocked=0, fail=0, locked_out=0, digit_cnt=0, fail counter 0, mismatch flag 0, timer 0.
- A press sampled at edge t updates digit_cnt at t+1.
- Final correct press at edge t: unlocked rises at t+1 and falls at t+1+OPEN_CYCLES.
- Final wrong press at edge t: fail is high in cycle t+1 only. locked_out (if triggered) rises at t+1.
- A press in the same cycle as the ENTRY timeout expiry: the press wins and the timer reloads.
- rst has priority over everything. Mid-operation it aborts immediately to the reset values, and any in-progress open or lockout is cancelled.

## Configuration

- CODE_LOCK_LOCKOUT_EN defined: the fail counter and LOCKOUT state are present, with behaviour as above.
- CODE_LOCK_LOCKOUT_EN undefined: no fail counter and no LOCKOUT state; locked_out is tied 0. A mismatch always returns to IDLE with a fail pulse. MAX_FAILS and LOCKOUT_CYCLES are ignored.

## Test plan

Bench parameters: CODE=8'hE4, CODE_LEN=4, OPEN_CYCLES=10, TIMEOUT_CYCLES=20, MAX_FAILS=3, LOCKOUT_CYCLES=30, macro defined.

- Correct code: pulse keys 4'b0001, 0010, 0100, 1000, spaced 5 cycles apart. digit_cnt steps 1,2,3,0. unlocked is high for exactly 10 cycles starting the cycle after the 4th pulse. fail stays 0.
- Wrong digit: sequence 0,1,3,3. Exactly one fail pulse in the cycle after the 4th press. unlocked stays 0. digit_cnt=0.
- Multi-key press: keys 0011 as the first press, then 1,2,3. Rejected with one fail pulse.
- Timeout: press 0, press 1, then idle 20 cycles. digit_cnt returns to 0 after exactly 20 cycles, with no fail pulse. The full correct code entered afterwards unlocks.
- Lockout: three wrong attempts. locked_out is high for 30 cycles after the 3rd fail pulse, and the correct code entered during that window is ignored. The correct code entered after the window unlocks.
- Reset mid-OPEN: rst asserted on cycle 5 of OPEN. unlocked is 0 the next cycle and all outputs hold reset values. Rerun with the macro undefined: three wrong attempts keep locked_out at 0.
